// File: rtl/flexctl_pkg.sv
// Shared definitions for the flexcounter job controller: FSM state
// encoding and the default sizing constants for the counter and the
// strobe-repeat field.
package flexctl_pkg;

    localparam int COUNTSIZE_DEF = 1024;
    localparam int REPWIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage : flexctl_pkg

// File: rtl/flexcounter_ctrl.sv
// Job controller for an external flexcounter. A job is a (period, repeats)
// pair: the counter is run with maxCount = period and the controller emits
// one tick per counter strobe until `repeats` strobes have been seen, then
// pulses done. The counter itself lives beside this block and is wired via
// the cnt_* ports.
//
// Request handshake: a job is transferred on a rising clk edge where
// req_valid and req_ready are both high. req_ready is high only in IDLE;
// while it is low the request is left untouched (not consumed) and the
// requester must keep req_valid, req_period and req_repeats stable until the
// transfer edge. A transferred job is never refused or dropped.
module flexcounter_ctrl
    import flexctl_pkg::*;
#(
    parameter int COUNTSIZE  = COUNTSIZE_DEF,
    parameter int COUNTWIDTH = $clog2(COUNTSIZE),
    parameter int REPWIDTH   = REPWIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [COUNTWIDTH-1:0] req_period,
    input  logic [REPWIDTH-1:0]   req_repeats,
    input  logic                  abort,
    output logic                  tick,
    output logic                  done,
    output logic                  busy,
    output logic [REPWIDTH-1:0]   ticks_left,
    output logic                  cnt_nRST,
    output logic                  cnt_enableCounter,
    output logic [COUNTWIDTH-1:0] cnt_maxCount,
    input  logic                  cnt_strobe,
    input  logic [COUNTWIDTH-1:0] cnt_count,
    // Debug observation of the FSM state (state_t encoding).
    output logic [1:0]            dbg_state
);

    state_t                r_state;
    state_t                w_next_state;
    logic [COUNTWIDTH-1:0] r_period;
    logic [COUNTWIDTH-1:0] w_next_period;
    logic [REPWIDTH-1:0]   r_ticks_left;
    logic [REPWIDTH-1:0]   w_next_ticks_left;
    logic                  w_tick;

    // The counter value is brought in for monitoring only; nothing here
    // depends on it.
    logic                  w_unused_cnt_count;
    assign w_unused_cnt_count = ^cnt_count;

    // State, latched period and remaining-strobe registers; reset wins over all.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state      <= IDLE;
            r_period     <= '0;
            r_ticks_left <= '0;
        end else begin
            r_state      <= w_next_state;
            r_period     <= w_next_period;
            r_ticks_left <= w_next_ticks_left;
        end
    end

    // Next-state logic: job acceptance, strobe counting, abort and completion.
    always_comb begin
        w_next_state      = r_state;
        w_next_period     = r_period;
        w_next_ticks_left = r_ticks_left;
        w_tick            = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    // A zero period would make the counter strobe every
                    // cycle with no wrap; treat it as the shortest legal one.
                    w_next_period     = (req_period == '0) ? COUNTWIDTH'(1) : req_period;
                    w_next_ticks_left = req_repeats;
                    w_next_state      = (req_repeats == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort outranks a coincident strobe: no tick, no done.
                    w_next_ticks_left = '0;
                    w_next_state      = IDLE;
                end else if (cnt_strobe) begin
                    w_tick            = 1'b1;
                    w_next_ticks_left = r_ticks_left - REPWIDTH'(1);
                    if (r_ticks_left == REPWIDTH'(1)) begin
                        w_next_state = FINISH;
                    end
                end
            end
            FINISH: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state; tick is the only input-dependent one.
    assign req_ready         = (r_state == IDLE);
    assign busy              = (r_state != IDLE);
    assign done              = (r_state == FINISH);
    assign cnt_nRST          = (r_state == RUN);
    assign cnt_enableCounter = (r_state == RUN);
    assign cnt_maxCount      = r_period;
    assign ticks_left        = r_ticks_left;
    assign tick              = w_tick;
    assign dbg_state         = r_state;

endmodule : flexcounter_ctrl

// File: tb/tb_flexcounter_ctrl.sv
// Bench for flexcounter_ctrl with a behavioural flexcounter alongside it.
module tb_flexcounter_ctrl;
  import flexctl_pkg::*;

  localparam int CW = 10;
  localparam int RW = 8;
  localparam int NV = 14;

  // ---------------- clock / reset / signals ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_period;
  logic [RW-1:0] req_repeats;
  logic          abort;
  logic          tick;
  logic          done;
  logic          busy;
  logic [RW-1:0] ticks_left;
  logic          cnt_nRST;
  logic          cnt_enableCounter;
  logic [CW-1:0] cnt_maxCount;
  logic          cnt_strobe;
  logic [CW-1:0] cnt_count;
  logic [1:0]    dbg_state;

  flexcounter_ctrl #(.COUNTSIZE(1024), .COUNTWIDTH(CW), .REPWIDTH(RW)) dut (
    .clk               (clk),
    .RST               (RST),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_period        (req_period),
    .req_repeats       (req_repeats),
    .abort             (abort),
    .tick              (tick),
    .done              (done),
    .busy              (busy),
    .ticks_left        (ticks_left),
    .cnt_nRST          (cnt_nRST),
    .cnt_enableCounter (cnt_enableCounter),
    .cnt_maxCount      (cnt_maxCount),
    .cnt_strobe        (cnt_strobe),
    .cnt_count         (cnt_count),
    .dbg_state         (dbg_state)
  );

  // Behavioural flexcounter: counts 0..maxCount while enabled, strobes at maxCount.
  logic [CW-1:0] cnt_q = '0;
  always @(posedge clk) begin
    if (!cnt_nRST) cnt_q <= '0;
    else if (cnt_enableCounter) cnt_q <= (cnt_q == cnt_maxCount) ? '0 : cnt_q + CW'(1);
  end
  assign cnt_count  = cnt_q;
  assign cnt_strobe = cnt_enableCounter && (cnt_q == cnt_maxCount);

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_ready, input logic e_busy,
                            input logic e_tick, input logic e_done, input int e_tl,
                            input logic e_nrst, input logic e_en, input int e_maxc);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(e_ready));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".tick"}, 32'(tick), 32'(e_tick));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".ticks_left"}, 32'(ticks_left), 32'(e_tl));
    chk({tag, ".cnt_nRST"}, 32'(cnt_nRST), 32'(e_nrst));
    chk({tag, ".cnt_enable"}, 32'(cnt_enableCounter), 32'(e_en));
    chk({tag, ".cnt_maxCount"}, 32'(cnt_maxCount), 32'(e_maxc));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are applied just after the falling edge and left to settle.
  task automatic set_in(input logic r, input logic v, input int p, input int n, input logic a);
    RST         = r;
    req_valid   = v;
    req_period  = CW'(p);
    req_repeats = RW'(n);
    abort       = a;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst; logic valid; int period; int reps; logic ab; logic chk;
    logic ready; logic busy; logic tick; logic done; int tl;
    logic nrst; logic en; int maxc;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mkv(input logic rst, input logic valid, input int p, input int n,
                               input logic ab, input logic c, input logic rd, input logic bz,
                               input logic tk, input logic dn, input int tl, input logic nr,
                               input logic en, input int mc);
    vec_t x;
    x.rst = rst; x.valid = valid; x.period = p; x.reps = n; x.ab = ab; x.chk = c;
    x.ready = rd; x.busy = bz; x.tick = tk; x.done = dn; x.tl = tl;
    x.nrst = nr; x.en = en; x.maxc = mc;
    return x;
  endfunction

  // ---------------- reference model for random phase ----------------
  bit m_active;
  int m_rel, m_p, m_r, m_period;

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tick_at[$];
    int tl_at[$];
    int done_at, n_done, ready_after, tl_done, seen;

    //            rst v  p  n  ab chk  rdy bsy tck dn tl nrst en maxc
    vecs[0]  = mkv(1, 0, 0, 0, 0, 0,   1,  0,  0,  0, 0, 0,   0, 0);
    vecs[1]  = mkv(1, 0, 0, 0, 0, 1,   1,  0,  0,  0, 0, 0,   0, 0);
    vecs[2]  = mkv(0, 0, 0, 0, 0, 1,   1,  0,  0,  0, 0, 0,   0, 0);
    vecs[3]  = mkv(0, 1, 0, 2, 0, 1,   1,  0,  0,  0, 0, 0,   0, 0);
    vecs[4]  = mkv(0, 0, 0, 0, 0, 1,   0,  1,  0,  0, 2, 1,   1, 1);
    vecs[5]  = mkv(0, 0, 0, 0, 0, 1,   0,  1,  1,  0, 2, 1,   1, 1);
    vecs[6]  = mkv(0, 1, 7, 3, 0, 1,   0,  1,  0,  0, 1, 1,   1, 1);
    vecs[7]  = mkv(0, 0, 0, 0, 0, 1,   0,  1,  1,  0, 1, 1,   1, 1);
    vecs[8]  = mkv(0, 1, 7, 3, 0, 1,   0,  1,  0,  1, 0, 0,   0, 1);
    vecs[9]  = mkv(0, 0, 0, 0, 0, 1,   1,  0,  0,  0, 0, 0,   0, 1);
    vecs[10] = mkv(0, 1, 9, 0, 0, 1,   1,  0,  0,  0, 0, 0,   0, 1);
    vecs[11] = mkv(0, 0, 0, 0, 1, 1,   0,  1,  0,  1, 0, 0,   0, 9);
    vecs[12] = mkv(0, 0, 0, 0, 0, 1,   1,  0,  0,  0, 0, 0,   0, 9);
    vecs[13] = mkv(0, 0, 0, 0, 1, 1,   1,  0,  0,  0, 0, 0,   0, 9);

    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].rst, vecs[i].valid, vecs[i].period, vecs[i].reps, vecs[i].ab);
      if (vecs[i].chk)
        check_outs($sformatf("vec%0d", i), vecs[i].ready, vecs[i].busy, vecs[i].tick,
                   vecs[i].done, vecs[i].tl, vecs[i].nrst, vecs[i].en, vecs[i].maxc);
      @(posedge clk);
      @(negedge clk);
    end

    // ---- period=4, repeats=3: ticks 5 cycles apart, done right after third ----
    set_in(0, 1, 4, 3, 0);
    step();
    set_in(0, 0, 0, 0, 0);
    done_at = -1; n_done = 0; ready_after = -1; tl_done = -1;
    for (int c = 1; c <= 40; c++) begin
      if (tick === 1'b1) begin
        tick_at.push_back(c);
        tl_at.push_back(int'(ticks_left));
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) begin
          done_at = c;
          tl_done = int'(ticks_left);
        end
      end
      if (done_at > 0 && c == done_at + 1) ready_after = int'(req_ready);
      step();
    end
    chk("a_tick_count", 32'(tick_at.size()), 32'd3);
    chk("a_tick1_cycle", 32'(qget(tick_at, 0)), 32'd5);
    chk("a_tick2_cycle", 32'(qget(tick_at, 1)), 32'd10);
    chk("a_tick3_cycle", 32'(qget(tick_at, 2)), 32'd15);
    chk("a_tl_at_tick1", 32'(qget(tl_at, 0)), 32'd3);
    chk("a_tl_at_tick2", 32'(qget(tl_at, 1)), 32'd2);
    chk("a_tl_at_tick3", 32'(qget(tl_at, 2)), 32'd1);
    chk("a_done_count", 32'(n_done), 32'd1);
    chk("a_done_cycle", 32'(done_at), 32'd16);
    chk("a_tl_at_done", 32'(tl_done), 32'd0);
    chk("a_ready_after", 32'(ready_after), 32'd1);

    // ---- period=10, repeats=5: abort on the 2nd strobe ----
    set_in(0, 1, 10, 5, 0);
    step();
    set_in(0, 0, 0, 0, 0);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (tick === 1'b1) begin seen = 1; break; end
      step();
    end
    chk("b_first_tick_seen", 32'(seen), 32'd1);
    step();
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (cnt_strobe === 1'b1) begin seen = 1; break; end
      step();
    end
    chk("b_second_strobe_seen", 32'(seen), 32'd1);
    set_in(0, 0, 0, 0, 1);
    chk("b_abort_tick", 32'(tick), 32'd0);
    chk("b_abort_done", 32'(done), 32'd0);
    step();
    set_in(0, 0, 0, 0, 0);
    check_outs("b_after_abort", 1, 0, 0, 0, 0, 0, 0, 10);
    step();
    chk("b_no_late_done", 32'(done), 32'd0);

    // ---- period=6, repeats=4: reset after the first tick, then a fresh job ----
    set_in(0, 1, 6, 4, 0);
    step();
    set_in(0, 0, 0, 0, 0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (tick === 1'b1) begin seen = 1; break; end
      step();
    end
    chk("c_first_tick_seen", 32'(seen), 32'd1);
    step();
    set_in(1, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0);
    check_outs("c_reset", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("c_state", 32'(dbg_state), 32'(IDLE));
    set_in(0, 1, 2, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0);
    check_outs("c_run", 0, 1, 0, 0, 1, 1, 1, 2);
    step();
    chk("c_rel2_tick", 32'(tick), 32'd0);
    step();
    chk("c_rel3_tick", 32'(tick), 32'd1);
    step();
    chk("c_done", 32'(done), 32'd1);
    step();

    // ---- randomized traffic against the arithmetic job model ----
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic r_i, v_i, a_i;
      int p_i, n_i, fin;
      r_i = (cyc == 0) ? 1'b1 : ($urandom_range(0, 149) == 0);
      v_i = ($urandom_range(0, 2) == 0);
      p_i = $urandom_range(0, 6);
      n_i = $urandom_range(0, 4);
      a_i = ($urandom_range(0, 24) == 0);
      set_in(r_i, v_i, p_i, n_i, a_i);
      fin = m_r * (m_p + 1) + 1;
      if (cyc > 0) begin
        if (!m_active)
          check_outs("rnd_idle", 1, 0, 0, 0, 0, 0, 0, m_period);
        else if (m_rel == fin)
          check_outs("rnd_finish", 0, 1, 0, 1, 0, 0, 0, m_period);
        else
          check_outs("rnd_run", 0, 1, ((m_rel % (m_p + 1)) == 0) && !a_i, 0,
                     m_r - (m_rel - 1) / (m_p + 1), 1, 1, m_period);
      end
      if (r_i) begin
        m_active = 0;
        m_period = 0;
      end else if (!m_active) begin
        if (v_i) begin
          m_active = 1;
          m_rel    = 1;
          m_p      = (p_i == 0) ? 1 : p_i;
          m_r      = n_i;
          m_period = m_p;
        end
      end else if (m_rel == fin) begin
        m_active = 0;
      end else if (a_i) begin
        m_active = 0;
      end else begin
        m_rel++;
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_flexcounter_ctrl
